// File: rtl/ahb_pwm_multi.sv
// ---------------------------------------------------------------------------
// ahb_pwm_multi
//   AHB-lite slave PWM generator. NUM_CH channels share one prescaler and one
//   period counter. Each channel has its own duty value. The counter runs in
//   edge-aligned or centre-aligned mode. PERIOD, DUTY and MODE are
//   double-buffered: the active copies are reloaded at each period end, on
//   a forced update, or continuously while the block is disabled.
//
//   Register map (word index = haddr[7:2]):
//     0x00 CTRL    [0] EN, [1] MODE (0 edge, 1 centre), [2] UPD (write-only
//                  pulse), [3] IE (only when PWM_IRQ_EN is defined)
//     0x04 PSC     prescale value P, counter ticks every P+1 clocks
//     0x08 PERIOD  pending period T
//     0x0C STATUS  [0] WRAP, sticky, write 1 to clear
//     0x10+4*i     DUTY[i] pending duty
//
//   Optional feature macro: PWM_IRQ_EN (adds O_irq and CTRL[3] IE).
//
// Ports
//   I_ahb_clk     core clock, sole clock domain
//   I_rst         synchronous active-high reset
//   I_ahb_hsel    slave select
//   I_ahb_htrans  transfer type, NONSEQ/SEQ start a transfer
//   I_ahb_hwrite  1 = write
//   I_ahb_haddr   byte address, bits [7:2] decoded
//   I_ahb_hsize   transfer size, every access is treated as a word
//   I_ahb_hwdata  write data (data phase)
//   O_ahb_hrdata  read data (data phase)
//   O_ahb_hresp   always OKAY
//   O_ahb_hready  always ready (zero wait state)
//   O_irq         WRAP & IE, registered (PWM_IRQ_EN only)
//   O_pwm         PWM outputs, bit i = channel i
// ---------------------------------------------------------------------------
module ahb_pwm_multi #(
    parameter int NUM_CH = 8,
    parameter int CNT_W  = 16,
    parameter int PSC_W  = 16
) (
    input  logic              I_ahb_clk,
    input  logic              I_rst,
    input  logic              I_ahb_hsel,
    input  logic [1:0]        I_ahb_htrans,
    input  logic              I_ahb_hwrite,
    input  logic [31:0]       I_ahb_haddr,
    input  logic [2:0]        I_ahb_hsize,
    input  logic [31:0]       I_ahb_hwdata,
    output logic [31:0]       O_ahb_hrdata,
    output logic [1:0]        O_ahb_hresp,
    output logic              O_ahb_hready,
`ifdef PWM_IRQ_EN
    output logic              O_irq,
`endif
    output logic [NUM_CH-1:0] O_pwm
);

    localparam logic [5:0] IDX_CTRL   = 6'd0;
    localparam logic [5:0] IDX_PSC    = 6'd1;
    localparam logic [5:0] IDX_PERIOD = 6'd2;
    localparam logic [5:0] IDX_STATUS = 6'd3;

    // bus pipeline
    logic             d_valid;
    logic             d_write;
    logic [5:0]       d_idx;
    logic             wr_en;

    // programming registers
    logic             ctrl_en;
    logic             ctrl_mode;
    logic             upd_req;
`ifdef PWM_IRQ_EN
    logic             ctrl_ie;
`endif
    logic [PSC_W-1:0] psc_val;
    logic [CNT_W-1:0] period_pend;
    logic [CNT_W-1:0] duty_pend [NUM_CH];

    // active (shadow) copies
    logic [CNT_W-1:0] period_act;
    logic [CNT_W-1:0] duty_act [NUM_CH];
    logic             mode_act;

    // counters and status
    logic [PSC_W-1:0] psc_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             dir;
    logic             dir_nxt;
    logic             tick;
    logic             period_end;
    logic             wrap;
    logic             wrap_clr;
    logic [NUM_CH-1:0] pwm_lvl;

    // Size, the unused address bits and the upper write-data bits carry no
    // meaning for this slave.
    logic             unused_ok;
    assign unused_ok = ^{I_ahb_hsize, I_ahb_haddr[31:8], I_ahb_haddr[1:0],
                         I_ahb_hwdata};

    assign O_ahb_hresp  = 2'b00;
    assign O_ahb_hready = 1'b1;

    // Address phase capture. hready is always high, so every valid address
    // phase is followed by its data phase in the very next cycle.
    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            d_valid <= 1'b0;
            d_write <= 1'b0;
            d_idx   <= '0;
        end else begin
            d_valid <= I_ahb_hsel & I_ahb_htrans[1];
            d_write <= I_ahb_hwrite;
            d_idx   <= I_ahb_haddr[7:2];
        end
    end

    assign wr_en    = d_valid & d_write;
    assign wrap_clr = wr_en && (d_idx == IDX_STATUS) && I_ahb_hwdata[0];

    // Register writes commit at the end of the data phase. UPD is not stored;
    // it becomes a one-cycle request acted on by the counter logic.
    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            ctrl_en     <= 1'b0;
            ctrl_mode   <= 1'b0;
            upd_req     <= 1'b0;
`ifdef PWM_IRQ_EN
            ctrl_ie     <= 1'b0;
`endif
            psc_val     <= '0;
            period_pend <= '0;
            for (int i = 0; i < NUM_CH; i++) duty_pend[i] <= '0;
        end else begin
            upd_req <= 1'b0;
            if (wr_en) begin
                case (d_idx)
                    IDX_CTRL: begin
                        ctrl_en   <= I_ahb_hwdata[0];
                        ctrl_mode <= I_ahb_hwdata[1];
                        upd_req   <= I_ahb_hwdata[2];
`ifdef PWM_IRQ_EN
                        ctrl_ie   <= I_ahb_hwdata[3];
`endif
                    end
                    IDX_PSC:    psc_val     <= I_ahb_hwdata[PSC_W-1:0];
                    IDX_PERIOD: period_pend <= I_ahb_hwdata[CNT_W-1:0];
                    default: ;
                endcase
                for (int i = 0; i < NUM_CH; i++) begin
                    if (d_idx == 6'(4 + i)) duty_pend[i] <= I_ahb_hwdata[CNT_W-1:0];
                end
            end
        end
    end

    // Read data comes straight from the registered address during the data
    // phase, so a read right after a write to the same register sees the new
    // value.
    always_comb begin
        O_ahb_hrdata = '0;
        if (d_valid && !d_write) begin
            case (d_idx)
                IDX_CTRL: begin
                    O_ahb_hrdata[0] = ctrl_en;
                    O_ahb_hrdata[1] = ctrl_mode;
`ifdef PWM_IRQ_EN
                    O_ahb_hrdata[3] = ctrl_ie;
`endif
                end
                IDX_PSC:    O_ahb_hrdata[PSC_W-1:0] = psc_val;
                IDX_PERIOD: O_ahb_hrdata[CNT_W-1:0] = period_pend;
                IDX_STATUS: O_ahb_hrdata[0]         = wrap;
                default: ;
            endcase
            for (int i = 0; i < NUM_CH; i++) begin
                if (d_idx == 6'(4 + i)) O_ahb_hrdata[CNT_W-1:0] = duty_pend[i];
            end
        end
    end

    // Next counter value. dir = 0 counts up, 1 counts down (centre mode).
    // A period ends when the edge counter wraps, when the centre counter
    // comes back down to 0, or on every tick when the period is 0. A pending
    // UPD suppresses the tick so that no period end (and no WRAP) happens.
    always_comb begin
        tick       = ctrl_en && !upd_req && (psc_cnt >= psc_val);
        period_end = 1'b0;
        cnt_nxt    = cnt;
        dir_nxt    = dir;
        if (tick) begin
            if (period_act == '0) begin
                cnt_nxt    = '0;
                dir_nxt    = 1'b0;
                period_end = 1'b1;
            end else if (!mode_act) begin
                if (cnt >= period_act) begin
                    cnt_nxt    = '0;
                    period_end = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
                dir_nxt = 1'b0;
            end else if (!dir && (cnt < period_act)) begin
                cnt_nxt = cnt + CNT_W'(1);
            end else begin
                cnt_nxt = cnt - CNT_W'(1);
                dir_nxt = 1'b1;
                if (cnt == CNT_W'(1)) begin
                    dir_nxt    = 1'b0;
                    period_end = 1'b1;
                end
            end
        end
    end

    // Counters and shadows. While disabled, or on a forced update, the
    // counters sit at their start point and the shadows track the pending
    // registers so the first counted cycle already uses them.
    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            psc_cnt    <= '0;
            cnt        <= '0;
            dir        <= 1'b0;
            period_act <= '0;
            mode_act   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= '0;
        end else if (!ctrl_en || upd_req) begin
            psc_cnt    <= '0;
            cnt        <= '0;
            dir        <= 1'b0;
            period_act <= period_pend;
            mode_act   <= ctrl_mode;
            for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_pend[i];
        end else begin
            psc_cnt <= tick ? '0 : psc_cnt + PSC_W'(1);
            cnt     <= cnt_nxt;
            dir     <= dir_nxt;
            if (period_end) begin
                period_act <= period_pend;
                mode_act   <= ctrl_mode;
                for (int i = 0; i < NUM_CH; i++) duty_act[i] <= duty_pend[i];
            end
        end
    end

    // Sticky WRAP flag; a period end in the same cycle as a clear wins.
    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            wrap <= 1'b0;
        end else if (period_end) begin
            wrap <= 1'b1;
        end else if (wrap_clr) begin
            wrap <= 1'b0;
        end
    end

    // Compare level per channel. In centre mode the counter peaks at T, so a
    // duty of T or more must be forced high rather than compared.
    always_comb begin
        pwm_lvl = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (duty_act[i] == '0) begin
                pwm_lvl[i] = 1'b0;
            end else if (mode_act && (duty_act[i] >= period_act)) begin
                pwm_lvl[i] = 1'b1;
            end else begin
                pwm_lvl[i] = (cnt < duty_act[i]);
            end
        end
    end

    // Registered pin drive, forced low while disabled.
    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            O_pwm <= '0;
        end else begin
            O_pwm <= ctrl_en ? pwm_lvl : '0;
        end
    end

`ifdef PWM_IRQ_EN
    // Registered interrupt request.
    always_ff @(posedge I_ahb_clk) begin
        if (I_rst) begin
            O_irq <= 1'b0;
        end else begin
            O_irq <= wrap & ctrl_ie;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_pwm_multi.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_ahb_pwm_multi
//   Drives ahb_pwm_multi through directed register sequences and a random
//   bus phase. A reference model tracks the PWM position inside the period
//   arithmetically (position modulo period length) and predicts pins, read
//   data, and the interrupt line every clock.
// ---------------------------------------------------------------------------
module tb_ahb_pwm_multi;

    localparam int NUM_CH = 8;
    localparam int CNT_W  = 16;
    localparam int PSC_W  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              hsel;
    logic [1:0]        htrans;
    logic              hwrite;
    logic [31:0]       haddr;
    logic [2:0]        hsize;
    logic [31:0]       hwdata;
    logic [31:0]       hrdata;
    logic [1:0]        hresp;
    logic              hready;
    logic [NUM_CH-1:0] pwm;
`ifdef PWM_IRQ_EN
    logic              irq;
`endif

    always #5 clk = ~clk;

    ahb_pwm_multi #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .PSC_W(PSC_W)) dut (
        .I_ahb_clk    (clk),
        .I_rst        (rst),
        .I_ahb_hsel   (hsel),
        .I_ahb_htrans (htrans),
        .I_ahb_hwrite (hwrite),
        .I_ahb_haddr  (haddr),
        .I_ahb_hsize  (hsize),
        .I_ahb_hwdata (hwdata),
        .O_ahb_hrdata (hrdata),
        .O_ahb_hresp  (hresp),
        .O_ahb_hready (hready),
`ifdef PWM_IRQ_EN
        .O_irq        (irq),
`endif
        .O_pwm        (pwm)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state: programming registers.
    int m_en, m_mode, m_ie, m_psc, m_per, m_wrap, m_upd;
    int m_duty [NUM_CH];
    // Reference model state: active copies and position in the period.
    int m_tact, m_mact, m_pdiv, m_pos;
    int m_dact [NUM_CH];
    logic [NUM_CH-1:0] m_pwm;
    int m_irq;
    // Transfer currently in its data phase.
    int          p_valid, p_write, p_idx;
    logic [31:0] p_wdata;

    // Compare one observed value against its expected value.
    task automatic checkOutput(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Period length in ticks for the active settings.
    function automatic int periodLen();
        if (m_tact == 0) return 1;
        return (m_mact != 0) ? 2 * m_tact : m_tact + 1;
    endfunction

    // Counter value implied by the position within the period.
    function automatic int cntValue();
        if (m_tact == 0) return 0;
        if (m_mact == 0) return m_pos;
        return (m_pos <= m_tact) ? m_pos : 2 * m_tact - m_pos;
    endfunction

    // Channel level for a given active duty.
    function automatic bit level(input int d);
        if (d == 0) return 1'b0;
        if (m_mact != 0 && d >= m_tact) return 1'b1;
        return cntValue() < d;
    endfunction

    function automatic logic [31:0] readVal(input int idx);
        logic [31:0] v;
        v = '0;
        if (idx == 0) begin
            v[0] = m_en[0];
            v[1] = m_mode[0];
`ifdef PWM_IRQ_EN
            v[3] = m_ie[0];
`endif
        end else if (idx == 1) v = 32'(m_psc);
        else if (idx == 2) v = 32'(m_per);
        else if (idx == 3) v = 32'(m_wrap);
        else if (idx >= 4 && idx < 4 + NUM_CH) v = 32'(m_duty[idx-4]);
        return v;
    endfunction

    task automatic loadShadows();
        m_tact = m_per;
        m_mact = m_mode;
        for (int i = 0; i < NUM_CH; i++) m_dact[i] = m_duty[i];
    endtask

    task automatic modelReset();
        m_en = 0; m_mode = 0; m_ie = 0; m_psc = 0; m_per = 0; m_wrap = 0; m_upd = 0;
        m_tact = 0; m_mact = 0; m_pdiv = 0; m_pos = 0; m_pwm = '0; m_irq = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_duty[i] = 0;
            m_dact[i] = 0;
        end
        p_valid = 0; p_write = 0; p_idx = 0; p_wdata = '0;
    endtask

    // Advance the model by one clock edge; wdata is the data-phase write data.
    task automatic modelEdge(input logic [31:0] wdata);
        logic [NUM_CH-1:0] pwm_n;
        bit pe;
        bit w1c;
        for (int i = 0; i < NUM_CH; i++) pwm_n[i] = (m_en != 0) && level(m_dact[i]);
        pe = 1'b0;
        if (m_en == 0 || m_upd != 0) begin
            m_pdiv = 0;
            m_pos  = 0;
            loadShadows();
        end else if (m_pdiv >= m_psc) begin
            m_pdiv = 0;
            m_pos++;
            if (m_pos >= periodLen()) begin
                m_pos = 0;
                pe    = 1'b1;
                loadShadows();
            end
        end else begin
            m_pdiv++;
        end
        m_irq = m_wrap & m_ie;
        w1c = (p_valid != 0) && (p_write != 0) && (p_idx == 3) && wdata[0];
        if (pe) m_wrap = 1;
        else if (w1c) m_wrap = 0;
        m_upd = 0;
        if (p_valid != 0 && p_write != 0) begin
            if (p_idx == 0) begin
                m_en   = int'(wdata[0]);
                m_mode = int'(wdata[1]);
                m_upd  = int'(wdata[2]);
`ifdef PWM_IRQ_EN
                m_ie   = int'(wdata[3]);
`endif
            end else if (p_idx == 1) m_psc = int'(wdata[PSC_W-1:0]);
            else if (p_idx == 2) m_per = int'(wdata[CNT_W-1:0]);
            else if (p_idx >= 4 && p_idx < 4 + NUM_CH) m_duty[p_idx-4] = int'(wdata[CNT_W-1:0]);
        end
        m_pwm = pwm_n;
    endtask

    // One bus clock: present a new address phase, drive the data phase of
    // the previous transfer, advance the model, and check all outputs.
    task automatic applyStimulus(input bit valid, input bit wr, input int idx,
                                 input logic [31:0] wdata);
        logic [31:0] junk;
        logic [5:0]  idx6;
        junk   = $urandom();
        idx6   = 6'(idx);
        hwdata = p_wdata;
        hsel   = valid | junk[4];
        htrans = valid ? 2'b10 : 2'b00;
        hwrite = wr;
        haddr  = {junk[31:8], idx6, junk[1:0]};
        hsize  = junk[7:5];
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            modelEdge(hwdata);
            p_valid = int'(valid);
            p_write = int'(wr);
            p_idx   = idx;
            p_wdata = wdata;
        end
        #1;
        checkOutput("pwm", 32'(pwm), 32'(m_pwm));
        checkOutput("bus_resp", {29'd0, hready, hresp}, 32'h4);
        if (p_valid != 0 && p_write == 0) checkOutput("rdata", hrdata, readVal(p_idx));
`ifdef PWM_IRQ_EN
        checkOutput("irq", 32'(irq), 32'(m_irq));
`endif
    endtask

    task automatic writeReg(input int idx, input logic [31:0] d);
        applyStimulus(1'b1, 1'b1, idx, d);
    endtask

    task automatic readReg(input int idx);
        applyStimulus(1'b0 | 1'b1, 1'b0, idx, 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 32'h0);
    endtask

    initial begin
        int h0, h1, h2, r, idx;
        logic [31:0] d;
        rst = 1'b1; hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
        haddr = '0; hsize = 3'b010; hwdata = '0;
        modelReset();
        idle(3);
        rst = 1'b0;

        // Every register reads 0 after reset.
        for (int i = 0; i < 24; i++) readReg(i);
        idle(1);

        // Edge mode: T=9, D0=3 (3 of 10 high), D1=0 (never), D2=10 (always).
        writeReg(1, 32'd0);
        writeReg(2, 32'd9);
        writeReg(4, 32'd3);
        writeReg(5, 32'd0);
        writeReg(6, 32'd10);
        writeReg(0, 32'd1);
        idle(4);
        h0 = 0; h1 = 0; h2 = 0;
        for (int i = 0; i < 20; i++) begin
            idle(1);
            h0 += int'(pwm[0]);
            h1 += int'(pwm[1]);
            h2 += int'(pwm[2]);
        end
        checkOutput("edge_high_cnt", 32'(h0), 32'd6);
        checkOutput("duty0_low_cnt", 32'(h1), 32'd0);
        checkOutput("dutymax_high_cnt", 32'(h2), 32'd20);

        // Shadowing: mid-period duty change, then forced update.
        idle(4);
        writeReg(4, 32'd7);
        idle(25);
        writeReg(4, 32'd2);
        idle(3);
        writeReg(0, 32'd5);
        idle(12);

        // Status: set by wraps, cleared by W1C.
        readReg(3);
        writeReg(3, 32'd1);
        readReg(3);
        idle(12);
        readReg(3);

        // Prescale + centre mode.
        writeReg(0, 32'd0);
        writeReg(1, 32'd1);
        writeReg(2, 32'd4);
        writeReg(4, 32'd2);
        writeReg(0, 32'd11);
        idle(40);
        readReg(0);

        // Period 0: constant level, WRAP every tick, W1C loses to the set.
        writeReg(0, 32'd0);
        writeReg(1, 32'd0);
        writeReg(2, 32'd0);
        writeReg(4, 32'd1);
        writeReg(0, 32'd9);
        idle(4);
        h0 = 0;
        for (int i = 0; i < 10; i++) begin
            idle(1);
            h0 += int'(pwm[0]);
        end
        checkOutput("period0_high_cnt", 32'(h0), 32'd10);
        writeReg(3, 32'd1);
        readReg(3);
        idle(2);

        // Reset in the middle of a running period.
        writeReg(2, 32'd7);
        writeReg(0, 32'd5);
        idle(5);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) readReg(i);

        // Random bus traffic against the model.
        for (int n = 0; n < 2000; n++) begin
            r = int'($urandom_range(0, 999));
            if (r < 3) begin
                rst = 1'b1;
                idle(1);
                rst = 1'b0;
            end else if (r < 450) begin
                idle(1);
            end else if (r < 700) begin
                readReg(int'($urandom_range(0, 23)));
            end else begin
                idx = int'($urandom_range(0, 23));
                d   = $urandom();
                case (idx)
                    0: begin
                        d[2] = ($urandom_range(0, 9) == 0);
                        d[0] = ($urandom_range(0, 4) != 0);
                    end
                    1: d = 32'($urandom_range(0, 3));
                    2: d = 32'($urandom_range(0, 12));
                    3: ;
                    default: if (idx < 4 + NUM_CH) d = 32'($urandom_range(0, 15));
                endcase
                writeReg(idx, d);
            end
        end
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
